// File: rtl/fg_period_timer.sv
// Timebase for the function generator: prescaled clock-enable tick, period counter
// register, and double-buffered waveform configuration that is swapped only at a period boundary.
module fg_period_timer #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16,
    parameter int PRESC_BITWIDTH    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         cfg_load_i,
    input  logic [PRESC_BITWIDTH-1:0]    cfg_presc_i,
    input  logic [COUNTER_BITWIDTH-1:0]  cfg_counter_i,
    input  logic [COUNTER_BITWIDTH-1:0]  cfg_on_counter_i,
    input  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_rise_i,
    input  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_fall_i,
    input  logic [WAVEFORM_BITWIDTH-1:0] cfg_amplitude_i,
    output logic                         cfg_pending_o,
    output logic                         clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]  CR_o,
    output logic                         period_start_o,
    output logic [COUNTER_BITWIDTH-1:0]  counter_o,
    output logic [COUNTER_BITWIDTH-1:0]  ON_counter_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
    output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [PRESC_BITWIDTH-1:0]    presc;
        logic [COUNTER_BITWIDTH-1:0]  counter;
        logic [COUNTER_BITWIDTH-1:0]  on_counter;
        logic [WAVEFORM_BITWIDTH-1:0] k_rise;
        logic [WAVEFORM_BITWIDTH-1:0] k_fall;
        logic [WAVEFORM_BITWIDTH-1:0] amplitude;
    } cfg_t;

    state_t                      r_state, w_state_next;
    cfg_t                        r_shadow, r_active, w_shadow_next, w_active_next, w_cfg_in;
    logic                        r_pending, w_pending_next;
    logic                        r_first, w_first_next;
    logic [PRESC_BITWIDTH-1:0]   r_presc_cnt, w_presc_cnt_next;
    logic [COUNTER_BITWIDTH-1:0] r_cr, w_cr_next;
    logic                        r_clk_en, w_clk_en_next;
    logic                        r_period_start, w_period_start_next;
    logic                        w_tick, w_wrap;
    logic [COUNTER_BITWIDTH:0]   w_cr_inc;

    assign w_cfg_in = '{presc:      cfg_presc_i,
                        counter:    cfg_counter_i,
                        on_counter: cfg_on_counter_i,
                        k_rise:     cfg_k_rise_i,
                        k_fall:     cfg_k_fall_i,
                        amplitude:  cfg_amplitude_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (en_i)  w_state_next = S_RUN;
            S_RUN:   if (!en_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Widened increment keeps the wrap compare exact even at CR = max.
    assign w_cr_inc = {1'b0, r_cr} + {{COUNTER_BITWIDTH{1'b0}}, 1'b1};
    assign w_tick   = (r_state == S_RUN) && (r_presc_cnt == r_active.presc);
    assign w_wrap   = w_tick && !r_first && (w_cr_inc >= {1'b0, r_active.counter});

    // Output / datapath next values
    always_comb begin
        w_shadow_next       = r_shadow;
        w_active_next       = r_active;
        w_pending_next      = r_pending;
        w_first_next        = r_first;
        w_presc_cnt_next    = '0;
        w_cr_next           = '0;
        w_clk_en_next       = 1'b0;
        w_period_start_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_first_next   = 1'b1;
                w_pending_next = 1'b0;
                if (cfg_load_i) begin
                    w_shadow_next = w_cfg_in;
                    w_active_next = w_cfg_in;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    // Leaving RUN: whatever is pending becomes active immediately.
                    w_pending_next = 1'b0;
                    if (cfg_load_i) begin
                        w_shadow_next = w_cfg_in;
                        w_active_next = w_cfg_in;
                    end else if (r_pending) begin
                        w_active_next = r_shadow;
                    end
                end else begin
                    w_cr_next        = r_cr;
                    w_presc_cnt_next = w_tick ? '0 : r_presc_cnt + 1'b1;
                    if (w_tick) begin
                        w_clk_en_next = 1'b1;
                        if (r_first) begin
                            w_first_next        = 1'b0;
                            w_cr_next           = '0;
                            w_period_start_next = 1'b1;
                        end else if (w_wrap) begin
                            w_cr_next           = '0;
                            w_period_start_next = 1'b1;
                            if (r_pending) begin
                                w_active_next  = r_shadow;
                                w_pending_next = 1'b0;
                            end
                        end else begin
                            w_cr_next = w_cr_inc[COUNTER_BITWIDTH-1:0];
                        end
                    end
                    // A load on the wrap edge lands in the shadow after the old one was applied.
                    if (cfg_load_i) begin
                        w_shadow_next  = w_cfg_in;
                        w_pending_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow       <= '0;
            r_active       <= '0;
            r_pending      <= 1'b0;
            r_first        <= 1'b0;
            r_presc_cnt    <= '0;
            r_cr           <= '0;
            r_clk_en       <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_shadow       <= w_shadow_next;
            r_active       <= w_active_next;
            r_pending      <= w_pending_next;
            r_first        <= w_first_next;
            r_presc_cnt    <= w_presc_cnt_next;
            r_cr           <= w_cr_next;
            r_clk_en       <= w_clk_en_next;
            r_period_start <= w_period_start_next;
        end
    end

    assign cfg_pending_o  = r_pending;
    assign clk_en_o       = r_clk_en;
    assign CR_o           = r_cr;
    assign period_start_o = r_period_start;
    assign counter_o      = r_active.counter;
    assign ON_counter_o   = r_active.on_counter;
    assign k_rise_o       = r_active.k_rise;
    assign k_fall_o       = r_active.k_fall;
    assign amplitude_o    = r_active.amplitude;

endmodule

// File: tb/tb_fg_period_timer.sv
// Bench for fg_period_timer: directed scenarios plus random traffic, every cycle
// compared against a countdown/period-level reference model.
module tb_fg_period_timer;
    localparam int CW = 32;
    localparam int WW = 16;
    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, en = 1'b0, load = 1'b0;
    logic [PW-1:0] presc_in = '0;
    logic [CW-1:0] cnt_in = '0, on_in = '0;
    logic [WW-1:0] kr_in = '0, kf_in = '0, amp_in = '0;

    logic          pending_o, clk_en_o, ps_o;
    logic [CW-1:0] cr_o, counter_o, on_o;
    logic [WW-1:0] kr_o, kf_o, amp_o;

    fg_period_timer #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW), .PRESC_BITWIDTH(PW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_load_i(load),
        .cfg_presc_i(presc_in), .cfg_counter_i(cnt_in), .cfg_on_counter_i(on_in),
        .cfg_k_rise_i(kr_in), .cfg_k_fall_i(kf_in), .cfg_amplitude_i(amp_in),
        .cfg_pending_o(pending_o), .clk_en_o(clk_en_o), .CR_o(cr_o),
        .period_start_o(ps_o), .counter_o(counter_o), .ON_counter_o(on_o),
        .k_rise_o(kr_o), .k_fall_o(kf_o), .amplitude_o(amp_o)
    );

    typedef struct {
        longint unsigned presc, counter, on_cnt, kr, kf, amp;
    } cfg_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: running flag, cycles left until the next tick, period position.
    bit              m_run, m_first, m_pend, m_clk_en, m_ps;
    longint unsigned m_wait, m_cr;
    cfg_t            m_sh, m_act;

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.presc = presc_in; c.counter = cnt_in; c.on_cnt = on_in;
        c.kr = kr_in; c.kf = kf_in; c.amp = amp_in;
        return c;
    endfunction

    function automatic cfg_t zero_cfg();
        cfg_t c;
        c.presc = 0; c.counter = 0; c.on_cnt = 0; c.kr = 0; c.kf = 0; c.amp = 0;
        return c;
    endfunction

    task automatic model_step();
        cfg_t c = cur_cfg();
        if (rst) begin
            m_run = 0; m_first = 0; m_pend = 0; m_clk_en = 0; m_ps = 0;
            m_cr = 0; m_wait = 0; m_sh = zero_cfg(); m_act = zero_cfg();
        end else if (!m_run) begin
            m_clk_en = 0; m_ps = 0; m_cr = 0; m_pend = 0;
            if (load) begin m_sh = c; m_act = c; end
            if (en) begin m_run = 1; m_first = 1; m_wait = m_act.presc; end
        end else if (!en) begin
            m_run = 0; m_clk_en = 0; m_ps = 0; m_cr = 0;
            if (load) begin m_sh = c; m_act = c; end
            else if (m_pend) m_act = m_sh;
            m_pend = 0;
        end else begin
            if (m_wait == 0) begin
                m_clk_en = 1;
                if (m_first) begin
                    m_first = 0; m_cr = 0; m_ps = 1;
                end else if (m_cr + 1 >= m_act.counter) begin
                    m_cr = 0; m_ps = 1;
                    if (m_pend) begin m_act = m_sh; m_pend = 0; end
                end else begin
                    m_cr = m_cr + 1; m_ps = 0;
                end
                m_wait = m_act.presc;
            end else begin
                m_clk_en = 0; m_ps = 0; m_wait = m_wait - 1;
            end
            if (load) begin m_sh = c; m_pend = 1; end
        end
    endtask

    function automatic bit next_edge_wraps();
        return m_run && en && !rst && m_wait == 0 && !m_first && (m_cr + 1 >= m_act.counter);
    endfunction

    task automatic compare_all();
        check_val("clk_en",       clk_en_o,  m_clk_en);
        check_val("CR",           cr_o,      m_cr);
        check_val("period_start", ps_o,      m_ps);
        check_val("pending",      pending_o, m_pend);
        check_val("counter",      counter_o, m_act.counter);
        check_val("on_counter",   on_o,      m_act.on_cnt);
        check_val("k_rise",       kr_o,      m_act.kr);
        check_val("k_fall",       kf_o,      m_act.kf);
        check_val("amplitude",    amp_o,     m_act.amp);
    endtask

    longint unsigned tick_log[$];
    bit              log_en = 0;

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (log_en && clk_en_o) tick_log.push_back(cr_o);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_cfg(input int unsigned p, input int unsigned c, input int unsigned a);
        presc_in = PW'(p); cnt_in = CW'(c); amp_in = WW'(a);
        on_in = CW'($urandom); kr_in = WW'($urandom); kf_in = WW'($urandom);
    endtask

    task automatic run_until_cr(input longint unsigned v, input int maxc);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            cycle();
            if (m_clk_en && m_cr == v) found = 1;
        end
        check_val("wait_cr", found, 1);
    endtask

    task automatic check_ticks(input string tag, input longint unsigned exp[6]);
        check_val({tag, "_count"}, tick_log.size(), 6);
        for (int i = 0; i < 6 && i < tick_log.size(); i++)
            check_val(tag, tick_log[i], exp[i]);
        tick_log.delete();
    endtask

    initial begin
        longint unsigned exp1[6] = '{0, 1, 2, 3, 0, 1};
        longint unsigned exp2[6] = '{2, 3, 0, 1, 0, 1};
        int n_ps;
        bit hit;

        // Reset state
        rst = 1; cycle();
        rst = 0; cycle();
        check_val("rst_clk_en", clk_en_o, 0);
        check_val("rst_cr", cr_o, 0);
        check_val("rst_pending", pending_o, 0);
        $display("reset: clk_en=%0d CR=%0d pending=%0d", clk_en_o, cr_o, pending_o);

        // Basic counting: presc=2, counter=4
        set_cfg(2, 4, 16'h0100); load = 1; cycle();
        load = 0; en = 1; cycle();
        log_en = 1; cycles(18); log_en = 0;
        check_ticks("seq_p2c4", exp1);
        $display("basic: presc=2 counter=4 CR=%0d", cr_o);

        // Buffered load at CR=1
        set_cfg(2, 2, 16'h1234); load = 1; cycle();
        load = 0;
        check_val("buf_pending", pending_o, 1);
        check_val("buf_counter_held", counter_o, 4);
        log_en = 1; cycles(18); log_en = 0;
        check_ticks("seq_reload", exp2);
        check_val("buf_counter", counter_o, 2);
        check_val("buf_amp", amp_o, 16'h1234);
        $display("reload: counter=%0d amplitude=0x%0h pending=%0d", counter_o, amp_o, pending_o);

        // Load coincident with a wrap tick
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (next_edge_wraps()) begin
                set_cfg(2, 3, 16'h5555); load = 1; cycle(); load = 0; hit = 1;
                check_val("coin_pending", pending_o, 1);
                check_val("coin_amp_old", amp_o, 16'h1234);
            end else cycle();
        end
        check_val("coin_found", hit, 1);
        cycles(30);
        check_val("coin_amp_new", amp_o, 16'h5555);
        $display("coincident load: amplitude=0x%0h counter=%0d", amp_o, counter_o);

        // presc=0, counter=1: continuous ticks, all period starts
        en = 0; cycle();
        set_cfg(0, 1, 16'h0042); load = 1; cycle();
        load = 0; en = 1; cycles(2);
        n_ps = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (clk_en_o && ps_o && cr_o == 0) n_ps++;
        end
        check_val("cont_ticks", n_ps, 8);
        $display("continuous: %0d period starts in 8 cycles", n_ps);

        // Reset at CR=2 with pending shadow
        en = 0; cycle();
        set_cfg(1, 4, 16'h0abc); load = 1; cycle();
        load = 0; en = 1;
        run_until_cr(1, 20);
        set_cfg(1, 5, 16'h7777); load = 1; cycle(); load = 0;
        run_until_cr(2, 20);
        check_val("pre_rst_pending", pending_o, 1);
        rst = 1; cycle(); rst = 0;
        check_val("mid_rst_cr", cr_o, 0);
        check_val("mid_rst_pending", pending_o, 0);
        check_val("mid_rst_counter", counter_o, 0);
        check_val("mid_rst_amp", amp_o, 0);
        cycle();
        check_val("post_rst_idle_tick", clk_en_o, 0);
        cycle();
        check_val("post_rst_tick", clk_en_o, 1);
        check_val("post_rst_cr", cr_o, 0);
        $display("mid-run reset: restart tick=%0d CR=%0d", clk_en_o, cr_o);

        // Enable dropped mid-period with pending shadow
        en = 0; cycle();
        set_cfg(1, 8, 16'h0111); load = 1; cycle();
        load = 0; en = 1; cycles(6);
        set_cfg(3, 6, 16'h2222); load = 1; cycle();
        load = 0; en = 0; cycle();
        check_val("drop_clk_en", clk_en_o, 0);
        check_val("drop_cr", cr_o, 0);
        check_val("drop_counter", counter_o, 6);
        check_val("drop_amp", amp_o, 16'h2222);
        check_val("drop_pending", pending_o, 0);
        $display("enable drop: counter=%0d amplitude=0x%0h", counter_o, amp_o);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 39) != 0);
            load = ($urandom_range(0, 11) == 0);
            if (load) set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom);
            cycle();
        end
        rst = 0; en = 0; load = 0;
        cycle();
        $display("random: 3000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
